// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset clear sweep and an entry 0 that always reads as zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       ready_o,
    output logic                       wr_err_o
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_req;

    always_comb begin
        wr_req = wr_en_i && (wr_addr_i != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= CLEAR;
            ptr      <= '0;
            ready_o  <= 1'b0;
            wr_err_o <= 1'b0;
        end else begin
            wr_err_o <= 1'b0;
            case (state)
                CLEAR: begin
                    // Writes arriving during the sweep are dropped and flagged.
                    wr_err_o <= wr_req;
                    if (ptr == '1) begin
                        state   <= READY;
                        ready_o <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                READY: begin
                    state   <= READY;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Entry 0 is zeroed by the sweep and never written, so it always reads 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_req) begin
                mem[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (state == READY) begin
                rd_data_o[k*DATA_W +: DATA_W] = mem[rd_addr_i[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
                if (wr_req && (rd_addr_i[k*ADDR_W +: ADDR_W] == wr_addr_i)) begin
                    rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: abstract model checked every cycle plus directed literal checks,
// and a second small instance (NUM_RD=4, DATA_W=16, ADDR_W=3).
module tb_regfile_mp;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             ready;
    logic             wr_err;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .ready_o(ready), .wr_err_o(wr_err)
    );

    logic        rst4;
    logic [11:0] rd_addr4;
    logic [63:0] rd_data4;
    logic        wr_en4;
    logic [2:0]  wr_addr4;
    logic [15:0] wr_data4;
    logic        ready4;
    logic        wr_err4;

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut4 (
        .clk_i(clk), .rst_i(rst4), .rd_addr_i(rd_addr4), .rd_data_o(rd_data4),
        .wr_en_i(wr_en4), .wr_addr_i(wr_addr4), .wr_data_i(wr_data4),
        .ready_o(ready4), .wr_err_o(wr_err4)
    );

    int compared   = 0;
    int mismatched = 0;
    bit cmp_en     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count sweep edges; once DEPTH of them pass, contents are all zero and writes land.
    int            sweep;
    bit            m_ready;
    bit            m_err;
    logic [DW-1:0] m_mem [DEPTH];

    always @(posedge clk) begin
        if (!rst) begin
            sweep   <= 0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
        end else if (!m_ready) begin
            m_err <= wr_en && (wr_addr != 0);
            sweep <= sweep + 1;
            if (sweep == DEPTH - 1) begin
                m_ready <= 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            end
        end else begin
            m_err <= 1'b0;
            if (wr_en && (wr_addr != 0)) m_mem[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input int k);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (!m_ready) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (wr_en && (wr_addr != 0) && (a == wr_addr)) return wr_data;
`endif
        return m_mem[a];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ready", ready, m_ready);
            check("model_wr_err", wr_err, m_err);
            for (int k = 0; k < NR; k++)
                check($sformatf("model_rd%0d", k), rd_data[k*DW +: DW], exp_rd(k));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst4 = 1'b0; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; rd_addr4 = '0;

        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        check("reset_ready", ready, 0);
        check("reset_wr_err", wr_err, 0);
        check("reset_rd", rd_data, 0);

        // Sweep: a write request before the 10th edge must be dropped and flagged.
        rst = 1'b1;
        rd_addr = {5'd31, 5'd5};
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en   = (i == 10);
            wr_addr = 5'd5;
            wr_data = 32'h55;
            tick();
            check("sweep_ready", ready, (i == DEPTH));
            check("sweep_rd", rd_data, (i == DEPTH) ? 64'h0 : 64'h0);
            if (i == 10) check("clear_err_set", wr_err, 1);
            if (i == 11) check("clear_err_clr", wr_err, 0);
        end
        wr_en = 1'b0;
        #1 check("entry5_after_drop", rd_data[0 +: DW], 0);

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd7, 5'd7};
        tick();
        wr_en = 1'b0;
        #1;
        check("rd7_port0", rd_data[0 +: DW], 32'hDEADBEEF);
        check("rd7_port1", rd_data[DW +: DW], 32'hDEADBEEF);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rd_addr = {5'd0, 5'd0};
        #1 check("rd0_during_write", rd_data, 0);
        tick();
        wr_en = 1'b0;
        #1;
        check("rd0_after_write", rd_data, 0);
        check("wr0_no_err", wr_err, 0);

        rd_addr = {5'd3, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("bypass_port1", rd_data[DW +: DW], 32'hA5A5A5A5);
`else
        check("nobypass_port1", rd_data[DW +: DW], 32'h0);
`endif
        check("bypass_port0_other", rd_data[0 +: DW], 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        #1 check("rd3_next_cycle", rd_data[DW +: DW], 32'hA5A5A5A5);

        for (int a = 1; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a);
            rd_addr = {AW'(a - 1), AW'(DEPTH - a)};
            tick();
        end
        wr_en = 1'b0;
        rd_addr = {5'd17, 5'd31};
        #1;
        check("fill_rd31", rd_data[0 +: DW], 31);
        check("fill_rd17", rd_data[DW +: DW], 17);

        // Mid-operation reset pulse with a concurrent write that must vanish silently.
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF;
        rd_addr = {5'd9, 5'd17};
        tick();
        check("rst_pulse_ready", ready, 0);
        check("rst_pulse_err", wr_err, 0);
        rst = 1'b1;
        wr_en = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            check("resweep_ready", ready, (i == DEPTH));
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {AW'(a), AW'(DEPTH - 1 - a)};
            #1 check("resweep_zero", rd_data, 0);
        end

        // Small configuration instance.
        tick();
        tick();
        rst4 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("small_ready", ready4, (i == 8));
        end
        for (int a = 1; a < 8; a++) begin
            wr_en4 = 1'b1; wr_addr4 = 3'(a); wr_data4 = 16'h1000 + 16'(a) * 16'h0111;
            tick();
        end
        wr_en4 = 1'b0;
        rd_addr4 = {3'd7, 3'd5, 3'd3, 3'd2};
        #1;
        check("small_port0", rd_data4[0 +: 16], 16'h1222);
        check("small_port1", rd_data4[16 +: 16], 16'h1333);
        check("small_port2", rd_data4[32 +: 16], 16'h1555);
        check("small_port3", rd_data4[48 +: 16], 16'h1777);
        check("small_wr_err", wr_err4, 0);
        rd_addr4 = {3'd0, 3'd1, 3'd4, 3'd6};
        #1 check("small_all", rd_data4, 64'h0000_1111_1444_1666);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
